// File: rtl/posit_encoder_8_pkg.sv
// Shared posit definitions: widths, the field bundle handed to the packer, and special encodings.
package posit_encoder_8_pkg;

    localparam int N  = 8;
    localparam int ES = 4;
    localparam int BS = $clog2(N);
    localparam int SW = ES + BS + 2;
    localparam int FW = N;

    // Regime index limits; anything outside saturates
    localparam int K_MAX = N - 2;
    localparam int K_MIN = -(N - 1);

    typedef struct packed {
        logic                 sign;
        logic                 inf;
        logic                 zero;
        logic signed [SW-1:0] scale;
        logic [FW-1:0]        frac;
        logic                 sticky;
    } posit_fields_t;

    localparam logic [N-1:0] NAR    = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] MAXPOS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MINPOS = {{(N-1){1'b0}}, 1'b1};

endpackage

// File: rtl/posit_encoder_8_if.sv
// Operand/result bundle for the posit packer.
interface posit_encoder_8_if;

    logic                 start;
    logic                 sign;
    logic                 in_inf;
    logic                 in_zero;
    logic signed [8:0]    scale;
    logic [7:0]           frac;
    logic                 sticky;
    logic [7:0]           result;
    logic                 inf;
    logic                 zero;
    logic                 done;

    modport master (
        output start, sign, in_inf, in_zero, scale, frac, sticky,
        input  result, inf, zero, done
    );

    modport slave (
        input  start, sign, in_inf, in_zero, scale, frac, sticky,
        output result, inf, zero, done
    );

endinterface

// File: rtl/DSR_right_N_S.sv
// Logarithmic logical right shifter: c = a >> b.
module DSR_right_N_S #(
    parameter int N = 16,
    parameter int S = 4
) (
    input  logic [N-1:0] a,
    input  logic [S-1:0] b,
    output logic [N-1:0] c
);

    // One conditional power-of-two shift per bit of the shift amount
    always_comb begin
        c = a;
        for (int unsigned i = 0; i < S; i++) begin
            if (b[i]) c = c >> (1 << i);
        end
    end

endmodule

// File: rtl/posit_encoder_8.sv
// Three-stage posit packer: split scale, build regime string, round and apply sign.
module posit_encoder_8 (
    input  logic               clk,
    input  logic               rst,
    posit_encoder_8_if.slave   bus
);

    import posit_encoder_8_pkg::*;

    localparam int TW  = 2 * N;
    localparam int KW  = BS + 1;
    localparam int PAD = TW - 1 - ES - FW;
    localparam logic [TW-1:0] ONES = '1;

    // ---------------- S1 ----------------
    posit_fields_t        in_f;
    logic signed [SW-1:0] k_in;
    logic signed [KW-1:0] k_clamped;
    logic                 sat_hi_in, sat_lo_in;

    logic                 v1_q, sign1_q, inf1_q, zero1_q, sathi1_q, satlo1_q, sticky1_q;
    logic signed [KW-1:0] k1_q;
    logic [ES-1:0]        e1_q;
    logic [FW-1:0]        frac1_q;

    // Floor-divide scale into regime index and detect saturation
    always_comb begin
        in_f      = '{sign: bus.sign, inf: bus.in_inf, zero: bus.in_zero,
                      scale: bus.scale, frac: bus.frac, sticky: bus.sticky};
        k_in      = $signed(in_f.scale) >>> ES;
        sat_hi_in = (k_in >= SW'(K_MAX));
        sat_lo_in = (k_in <= SW'(K_MIN));
        k_clamped = sat_hi_in ? KW'(K_MAX) : (sat_lo_in ? KW'(K_MIN) : k_in[KW-1:0]);
    end

    // Stage 1 register: operand capture
    always_ff @(posedge clk) begin
        if (rst) v1_q <= 1'b0;
        else     v1_q <= bus.start;
        if (bus.start) begin
            sign1_q   <= in_f.sign;
            inf1_q    <= in_f.inf;
            zero1_q   <= in_f.zero;
            sathi1_q  <= sat_hi_in;
            satlo1_q  <= sat_lo_in;
            k1_q      <= k_clamped;
            e1_q      <= in_f.scale[ES-1:0];
            frac1_q   <= in_f.frac;
            sticky1_q <= in_f.sticky;
        end
    end

    // ---------------- S2 ----------------
    logic            k_neg, lost;
    logic [BS-1:0]   r;
    logic [TW-1:0]   tmp0, shifted, tmp;
    logic [N-2:0]    mag_d;
    logic            guard_d, st_d;

    logic            v2_q, sign2_q, inf2_q, zero2_q, sathi2_q, satlo2_q, guard2_q, st2_q;
    logic [N-2:0]    mag2_q;

    DSR_right_N_S #(.N(TW), .S(BS)) u_regime_shift (
        .a (tmp0),
        .b (r),
        .c (shifted)
    );

    // Terminator, exponent and fraction shifted under the regime run; the run bits are OR'd in
    always_comb begin
        k_neg = k1_q[KW-1];
        r     = k_neg ? BS'(-k1_q) : BS'(k1_q + KW'(1));
        tmp0  = {k_neg, e1_q, frac1_q, {PAD{1'b0}}};
        tmp   = shifted | (k_neg ? '0 : ~(ONES >> r));
        // bits pushed off the bottom of the shifter still count toward sticky
        lost  = |(tmp0 & ~(ONES << r));
        mag_d   = tmp[TW-1 -: N-1];
        guard_d = tmp[TW-N];
        st_d    = (|tmp[TW-N-1:0]) | sticky1_q | lost;
    end

    // Stage 2 register: unrounded magnitude plus rounding bits
    always_ff @(posedge clk) begin
        if (rst) v2_q <= 1'b0;
        else     v2_q <= v1_q;
        if (v1_q) begin
            sign2_q  <= sign1_q;
            inf2_q   <= inf1_q;
            zero2_q  <= zero1_q;
            sathi2_q <= sathi1_q;
            satlo2_q <= satlo1_q;
            mag2_q   <= mag_d;
            guard2_q <= guard_d;
            st2_q    <= st_d;
        end
    end

    // ---------------- S3 ----------------
    logic [N-1:0] rounded;
    logic [N-2:0] mag_fin;
    logic [N-1:0] result_d;
    logic         inf_d, zero_d;

    logic [N-1:0] result_q;
    logic         inf_q, zero_q, done_q;

    // Round to nearest even, clamp away from zero/NaR, then apply specials and sign
    always_comb begin
        rounded = {1'b0, mag2_q} + N'(guard2_q & (st2_q | mag2_q[0]));
        if (sathi2_q)                  mag_fin = MAXPOS[N-2:0];
        else if (satlo2_q)             mag_fin = MINPOS[N-2:0];
        else if (rounded[N-1])         mag_fin = MAXPOS[N-2:0];
        else if (rounded[N-2:0] == '0) mag_fin = MINPOS[N-2:0];
        else                           mag_fin = rounded[N-2:0];
        result_d = sign2_q ? -{1'b0, mag_fin} : {1'b0, mag_fin};
        inf_d    = 1'b0;
        zero_d   = 1'b0;
        if (inf2_q) begin
            result_d = NAR;
            inf_d    = 1'b1;
        end else if (zero2_q) begin
            result_d = '0;
            zero_d   = 1'b1;
        end
    end

    // Stage 3 register: outputs hold until the next valid result
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q   <= 1'b0;
            result_q <= '0;
            inf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            done_q <= v2_q;
            if (v2_q) begin
                result_q <= result_d;
                inf_q    <= inf_d;
                zero_q   <= zero_d;
            end
        end
    end

    assign bus.result = result_q;
    assign bus.inf    = inf_q;
    assign bus.zero   = zero_q;
    assign bus.done   = done_q;

endmodule
